operand_loader: RTL and testbench

- Upstream input stage for the 4-bit logic-gate unit on the FPGA board.
- Takes raw board switches and two push-buttons, debounces the buttons, and latches the switch value into operand A and then operand B.
- Drives registered, stable `a`/`b` buses straight into the gate block's `a`/`b` inputs.
- Asserts `valid` once both operands are loaded.

---
 rtl/operand_loader.sv | 148 ++++++++++++++
 tb/tb_operand_loader.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : operand_loader
// Purpose  : Debounces the load/clear push-buttons and latches the board
//            switches into operand A, then operand B, for the 4-bit gate unit.
//            Raises valid once both operands are held.
// Revision : 1.0 - initial release
// ============================================================================
module operand_loader #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_load,
  input  logic             btn_clear,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             valid,
  output logic [1:0]       state_led
);

  // Counter must reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int               c_CNT_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    LOAD_A = 2'b00,
    LOAD_B = 2'b01,
    READY  = 2'b10
  } state_t;

  // Bit 0 is the load button, bit 1 the clear button.
  logic [1:0] w_raw;
  logic [1:0] w_pulse;

  assign w_raw = {btn_clear, btn_load};

  // Identical conditioning chain for each button: sync, debounce, edge pulse.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic               r_sync1;
    logic               r_sync2;
    logic               r_level;
    logic               r_level_prev;
    logic               r_pulse;
    logic [c_CNT_W-1:0] r_cnt;

    // Synchronize, accept a level only after it has been stable long enough,
    // and emit one pulse per accepted press (releases produce nothing).
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_sync1      <= 1'b0;
        r_sync2      <= 1'b0;
        r_level      <= 1'b0;
        r_level_prev <= 1'b0;
        r_pulse      <= 1'b0;
        r_cnt        <= '0;
      end else begin
        r_sync1 <= w_raw[gi];
        r_sync2 <= r_sync1;
        if (r_sync2 == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_CNT_MAX) begin
          r_level <= ~r_level;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
        r_level_prev <= r_level;
        r_pulse      <= r_level & ~r_level_prev;
      end
    end

    assign w_pulse[gi] = r_pulse;
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] w_a_nxt;
  logic [WIDTH-1:0] w_b_nxt;
  logic             r_valid;
  logic             w_valid_nxt;

  // Operand/state registers; everything updates together on a pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= LOAD_A;
      r_a     <= '0;
      r_b     <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_a     <= w_a_nxt;
      r_b     <= w_b_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  // Next-state logic: clear beats load; an unknown encoding falls back to LOAD_A.
  always_comb begin
    w_state_nxt = r_state;
    w_a_nxt     = r_a;
    w_b_nxt     = r_b;
    if (w_pulse[1]) begin
      w_state_nxt = LOAD_A;
      w_a_nxt     = '0;
      w_b_nxt     = '0;
    end else begin
      case (r_state)
        LOAD_A: begin
          if (w_pulse[0]) begin
            w_a_nxt     = sw;
            w_state_nxt = LOAD_B;
          end
        end
        LOAD_B: begin
          if (w_pulse[0]) begin
            w_b_nxt     = sw;
            w_state_nxt = READY;
          end
        end
        READY: begin
          // b keeps its old value until it is reloaded.
          if (w_pulse[0]) begin
            w_a_nxt     = sw;
            w_state_nxt = LOAD_B;
          end
        end
        default: begin
          w_state_nxt = LOAD_A;
          w_a_nxt     = '0;
          w_b_nxt     = '0;
        end
      endcase
    end
    w_valid_nxt = (w_state_nxt == READY);
  end

  assign a         = r_a;
  assign b         = r_b;
  assign valid     = r_valid;
  assign state_led = r_state;

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_operand_loader
// Purpose  : Self-checking bench for operand_loader: expected outputs are
//            queued when a press is driven and compared when the load lands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_operand_loader;

  localparam int c_W   = 4;
  localparam int c_DB  = 4;
  localparam int c_LAT = c_DB + 4;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [c_W-1:0] sw;
  logic           btn_load;
  logic           btn_clear;
  logic [c_W-1:0] a;
  logic [c_W-1:0] b;
  logic           valid;
  logic [1:0]     state_led;

  always #5 clk = ~clk;

  operand_loader #(
    .WIDTH           (c_W),
    .DEBOUNCE_CYCLES (c_DB)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sw        (sw),
    .btn_load  (btn_load),
    .btn_clear (btn_clear),
    .a         (a),
    .b         (b),
    .valid     (valid),
    .state_led (state_led)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  logic [10:0] sb_q[$];

  // Reference model of the operand registers: {a, b, valid, state_led}.
  logic [3:0]  m_a;
  logic [3:0]  m_b;
  logic        m_valid;
  logic [1:0]  m_led;
  logic [10:0] t_old;
  logic [10:0] t_exp;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [10:0] cur_val();
    return {m_a, m_b, m_valid, m_led};
  endfunction

  task automatic check_outputs(input string tag, input logic [10:0] e);
    check({tag, ".a"},     32'(a),         32'(e[10:7]));
    check({tag, ".b"},     32'(b),         32'(e[6:3]));
    check({tag, ".valid"}, 32'(valid),     32'(e[2]));
    check({tag, ".state"}, 32'(state_led), 32'(e[1:0]));
  endtask

  task automatic model_reset();
    m_a = 4'h0; m_b = 4'h0; m_valid = 1'b0; m_led = 2'b00;
  endtask

  task automatic model_step(input logic ld, input logic cl, input logic [3:0] v);
    if (cl) begin
      m_a = 4'h0; m_b = 4'h0; m_led = 2'b00;
    end else if (ld) begin
      case (m_led)
        2'b00:   begin m_a = v; m_led = 2'b01; end
        2'b01:   begin m_b = v; m_led = 2'b10; end
        default: begin m_a = v; m_led = 2'b01; end
      endcase
    end
    m_valid = (m_led == 2'b10);
  endtask

  task automatic pop_and_check(input string tag);
    if (sb_q.size() == 0) begin
      check({tag, ".sb_empty"}, 32'd1, 32'd0);
    end else begin
      t_exp = sb_q.pop_front();
      check_outputs(tag, t_exp);
    end
  endtask

  // Press load and/or clear for `hold` cycles; sw switches to v2 after the load lands.
  task automatic press(input logic ld, input logic cl, input logic [3:0] v,
                       input logic [3:0] v2, input int hold, input string tag);
    t_old = cur_val();
    model_step(ld, cl, v);
    sb_q.push_back(cur_val());
    sw = v; btn_load = ld; btn_clear = cl;
    for (int k = 1; (k <= hold) || (k <= c_LAT); k++) begin
      @(posedge clk); #1;
      if (k == c_LAT - 1) check_outputs({tag, "@early"}, t_old);
      if (k == c_LAT) begin
        pop_and_check(tag);
        sw = v2;
      end
      if (k == hold) begin
        btn_load = 1'b0; btn_clear = 1'b0;
      end
    end
    repeat (3 * c_DB) @(posedge clk);
    #1;
    check_outputs({tag, "@settle"}, cur_val());
  endtask

  // Drive a short bouncing pattern on load (bit 0 first); nothing may change.
  task automatic bounce(input logic [7:0] pat, input int len, input string tag);
    for (int k = 0; k < len; k++) begin
      btn_load = pat[k];
      @(posedge clk); #1;
    end
    btn_load = 1'b0;
    repeat (3 * c_DB) @(posedge clk);
    #1;
    check_outputs(tag, cur_val());
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not end, got running expected finished");
    $fatal(1);
  end

  initial begin
    sw = 4'h0; btn_load = 1'b0; btn_clear = 1'b0; rst_n = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", cur_val());
    rst_n = 1'b1;

    press(1'b1, 1'b0, 4'hA, 4'hA, c_LAT, "load_a");
    press(1'b1, 1'b0, 4'h5, 4'h5, c_LAT, "load_b");
    press(1'b1, 1'b0, 4'hC, 4'hC, c_LAT, "reload_a");
    bounce(8'b0000_0101, 4, "bounce");
    bounce(8'b0000_0111, 3, "glitch3");
    press(1'b1, 1'b0, 4'hA, 4'hA, c_DB, "press4");
    press(1'b1, 1'b1, 4'h6, 4'h6, c_LAT, "clear_prio");
    press(1'b1, 1'b0, 4'h3, 4'hF, 50, "hold");

    // Reset lands while a press is only partly debounced.
    sw = 4'h7; btn_load = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    model_reset();
    check_outputs("mid_reset", cur_val());
    rst_n = 1'b1;
    t_old = cur_val();
    model_step(1'b1, 1'b0, 4'h7);
    sb_q.push_back(cur_val());
    for (int k = 1; k <= c_LAT; k++) begin
      @(posedge clk); #1;
      if (k == c_LAT - 1) check_outputs("after_reset@early", t_old);
      if (k == c_LAT) pop_and_check("after_reset");
    end
    btn_load = 1'b0;
    repeat (3 * c_DB) @(posedge clk);
    #1;
    check_outputs("after_reset@settle", cur_val());

    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
